// File: rtl/l2_cache_control_nway_if.sv
// Request, array-control, pmem and statistics signals of the N-way L2 controller.
// The master side drives requests and array lookup results; the slave side is the controller.
interface l2_cache_control_nway_if #(
    parameter int WAYS    = 4,
    parameter int WAY_W   = $clog2(WAYS),
    parameter int COUNT_W = 32
);
    // L1-side request port
    logic               l2cmem_read;
    logic               l2cmem_write;
    logic               l2cmem_resp;

    // Tag/data array lookup results
    logic               hit;
    logic [WAYS-1:0]    which_way_hit;
    logic [WAY_W-1:0]   lru_way;
    logic               dirty_bit_out;

    // Array write controls and datapath mux selects
    logic               cache_write;
    logic               valid_bit_in;
    logic               dirty_bit_in;
    logic               dirty_write_sel;
    logic [WAY_W-1:0]   way_select;
    logic               lru_update;

    // Physical memory handshake
    logic               ewb_blocking;
    logic               pmem_resp;
    logic               pmem_addr_sel;
    logic               pmem_read;
    logic               pmem_write;

    // Statistics
    logic               counter_clear;
    logic [COUNT_W-1:0] hit_count;
    logic [COUNT_W-1:0] miss_count;
    logic [COUNT_W-1:0] wb_count;
    logic               multi_hit_err;

    modport master (
        output l2cmem_read, l2cmem_write, hit, which_way_hit, lru_way, dirty_bit_out,
               ewb_blocking, pmem_resp, counter_clear,
        input  l2cmem_resp, cache_write, valid_bit_in, dirty_bit_in, dirty_write_sel,
               way_select, pmem_addr_sel, pmem_read, pmem_write, lru_update,
               hit_count, miss_count, wb_count, multi_hit_err
    );

    modport slave (
        input  l2cmem_read, l2cmem_write, hit, which_way_hit, lru_way, dirty_bit_out,
               ewb_blocking, pmem_resp, counter_clear,
        output l2cmem_resp, cache_write, valid_bit_in, dirty_bit_in, dirty_write_sel,
               way_select, pmem_addr_sel, pmem_read, pmem_write, lru_update,
               hit_count, miss_count, wb_count, multi_hit_err
    );
endinterface

// File: rtl/l2_cache_control_nway.sv
// N-way set-associative write-back/write-allocate L2 controller FSM with
// configurable array latency, eviction-buffer stall, saturating statistics
// counters and a sticky multi-hit error flag.
module l2_cache_control_nway #(
    parameter int WAYS         = 4,
    parameter int WAY_W        = $clog2(WAYS),
    parameter int ACCESS_DELAY = 2,
    parameter int COUNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    l2_cache_control_nway_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, CHECK, RESP, WB, FILL, UPDATE} state_t;

    // LOOKUP lasts ACCESS_DELAY cycles, so the down-counter starts one below it.
    localparam int               DELAY_LOAD_I = (ACCESS_DELAY > 0) ? ACCESS_DELAY - 1 : 0;
    localparam logic [2:0]       DELAY_LOAD   = DELAY_LOAD_I[2:0];
    localparam logic [COUNT_W-1:0] CNT_MAX    = '1;

    state_t             r_state, w_state_next;
    logic [2:0]         r_delay;
    logic               r_missed;
    logic               r_wb_active;
    logic [WAY_W-1:0]   r_resp_way;
    logic               r_multi_hit_err;

    logic [WAY_W-1:0]   w_hit_way;
    logic               w_hit_bad;
    logic               w_req_write;
    logic               w_resp, w_cache_write, w_valid_in, w_dirty_in, w_dirty_sel;
    logic [WAY_W-1:0]   w_way;
    logic               w_addr_sel, w_pmem_read, w_pmem_write, w_lru_update;
    logic [2:0]         w_inc;

    // A simultaneous read and write is handled as a write.
    assign w_req_write = bus.l2cmem_write;
    assign w_hit_bad   = (bus.which_way_hit == '0) ||
                         ((bus.which_way_hit & (bus.which_way_hit - WAYS'(1))) != '0);

    // Lowest set bit of the hit vector picks the way, so a malformed vector still resolves deterministically.
    always_comb begin
        w_hit_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (bus.which_way_hit[i]) w_hit_way = WAY_W'(i);
        end
    end

    // Next-state and output decode; everything idles at zero.
    always_comb begin
        w_state_next  = r_state;
        w_resp        = 1'b0;
        w_cache_write = 1'b0;
        w_valid_in    = 1'b0;
        w_dirty_in    = 1'b0;
        w_dirty_sel   = 1'b0;
        w_way         = '0;
        w_addr_sel    = 1'b0;
        w_pmem_read   = 1'b0;
        w_pmem_write  = 1'b0;
        w_lru_update  = 1'b0;
        w_inc         = 3'b000;   // {writeback, miss, hit}
        case (r_state)
            IDLE: begin
                if (bus.l2cmem_read || bus.l2cmem_write) begin
                    if (ACCESS_DELAY == 0) w_state_next = CHECK;
                    else                   w_state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                w_way = bus.lru_way;
                if (r_delay == 3'd0) w_state_next = CHECK;
            end
            CHECK: begin
                if (!bus.ewb_blocking) begin
                    if (bus.hit) begin
                        w_way = w_hit_way;
                        if (w_req_write) begin
                            w_cache_write = 1'b1;
                            w_valid_in    = 1'b1;
                            w_dirty_in    = 1'b1;
                            w_dirty_sel   = 1'b1;
                        end
                        // A hit after a refill completes a miss, so it is not a hit statistic.
                        w_inc[0]     = !r_missed;
                        w_state_next = RESP;
                    end else begin
                        w_inc[1] = 1'b1;
                        if (bus.dirty_bit_out) w_state_next = WB;
                        else                   w_state_next = FILL;
                    end
                end
            end
            RESP: begin
                w_resp       = 1'b1;
                w_lru_update = 1'b1;
                w_way        = r_resp_way;
                w_state_next = IDLE;
            end
            WB: begin
                w_way        = bus.lru_way;
                w_addr_sel   = 1'b1;
                // Once the write has started it must not drop if the buffer fills mid-transfer.
                w_pmem_write = !bus.ewb_blocking || r_wb_active;
                if (bus.pmem_resp) begin
                    w_inc[2]     = 1'b1;
                    w_state_next = FILL;
                end
            end
            FILL: begin
                w_pmem_read = 1'b1;
                if (bus.pmem_resp) w_state_next = UPDATE;
            end
            UPDATE: begin
                w_way         = bus.lru_way;
                w_cache_write = 1'b1;
                w_valid_in    = 1'b1;
                if (ACCESS_DELAY == 0) w_state_next = CHECK;
                else                   w_state_next = LOOKUP;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register plus the bookkeeping that travels with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_delay         <= 3'd0;
            r_missed        <= 1'b0;
            r_wb_active     <= 1'b0;
            r_resp_way      <= '0;
            r_multi_hit_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == LOOKUP && r_state != LOOKUP) r_delay <= DELAY_LOAD;
            else if (r_state == LOOKUP && r_delay != 3'd0)   r_delay <= r_delay - 3'd1;
            if (r_state == RESP)  r_missed <= 1'b0;
            else if (w_inc[1])    r_missed <= 1'b1;
            r_wb_active <= (r_state == WB) && w_pmem_write && !bus.pmem_resp;
            if (r_state == CHECK && w_state_next == RESP) r_resp_way <= w_hit_way;
            if (r_state == CHECK && bus.hit && w_hit_bad)  r_multi_hit_err <= 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cnt
            logic [COUNT_W-1:0] r_cnt;
            // Saturating event counter; clear takes priority over a same-cycle increment.
            always_ff @(posedge clk) begin
                if (rst || bus.counter_clear)           r_cnt <= '0;
                else if (w_inc[gi] && r_cnt != CNT_MAX) r_cnt <= r_cnt + COUNT_W'(1);
            end
        end
    endgenerate

    assign bus.l2cmem_resp     = w_resp;
    assign bus.cache_write     = w_cache_write;
    assign bus.valid_bit_in    = w_valid_in;
    assign bus.dirty_bit_in    = w_dirty_in;
    assign bus.dirty_write_sel = w_dirty_sel;
    assign bus.way_select      = w_way;
    assign bus.pmem_addr_sel   = w_addr_sel;
    assign bus.pmem_read       = w_pmem_read;
    assign bus.pmem_write      = w_pmem_write;
    assign bus.lru_update      = w_lru_update;
    assign bus.hit_count       = g_cnt[0].r_cnt;
    assign bus.miss_count      = g_cnt[1].r_cnt;
    assign bus.wb_count        = g_cnt[2].r_cnt;
    assign bus.multi_hit_err   = r_multi_hit_err;
endmodule

// File: tb/tb_l2_cache_control_nway.sv
// Directed bench for the N-way L2 controller: WAYS=4, ACCESS_DELAY=2, COUNT_W=2.
// Inputs change 1 ns after the rising edge, outputs are sampled 2 ns after it.
module tb_l2_cache_control_nway;
    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    l2_cache_control_nway_if #(.WAYS(4), .COUNT_W(2)) bus ();

    l2_cache_control_nway #(.WAYS(4), .ACCESS_DELAY(2), .COUNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        bus.counter_clear = 1'b1;
        tick();
        bus.counter_clear = 1'b0;
    endtask

    // Runs one request with hit=1 until l2cmem_resp; returns its cycle and the CHECK-cycle way.
    task automatic do_req(input logic wr, input logic [3:0] which, input bit clr_in_check,
                          output int cyc, output logic [1:0] chk_way);
        logic [1:0] prev_way;
        prev_way = 2'd0;
        cyc = -1;
        chk_way = 2'd0;
        bus.l2cmem_read   = !wr;
        bus.l2cmem_write  = wr;
        bus.hit           = 1'b1;
        bus.which_way_hit = which;
        for (int c = 0; c < 30; c++) begin
            bus.counter_clear = clr_in_check && (c == 3);
            #1;
            if (bus.l2cmem_resp) begin
                cyc = c;
                chk_way = prev_way;
                bus.l2cmem_read  = 1'b0;
                bus.l2cmem_write = 1'b0;
                bus.counter_clear = 1'b0;
                tick();
                break;
            end
            prev_way = bus.way_select;
            tick();
        end
        bus.l2cmem_read   = 1'b0;
        bus.l2cmem_write  = 1'b0;
        bus.counter_clear = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] strobes;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        strobes = {bus.l2cmem_resp, bus.cache_write, bus.valid_bit_in, bus.dirty_bit_in,
                   bus.dirty_write_sel, bus.pmem_addr_sel, bus.pmem_read, bus.pmem_write,
                   bus.lru_update};
        n_vec++; if (strobes !== 9'd0) begin n_miss++; $display("FAIL reset_strobes: got %b expected 000000000", strobes); end
        n_vec++; if (bus.way_select !== 2'd0) begin n_miss++; $display("FAIL reset_way: got %0d expected 0", bus.way_select); end
        n_vec++; if (bus.hit_count !== 2'd0) begin n_miss++; $display("FAIL reset_hit_count: got %0d expected 0", bus.hit_count); end
        n_vec++; if (bus.miss_count !== 2'd0) begin n_miss++; $display("FAIL reset_miss_count: got %0d expected 0", bus.miss_count); end
        n_vec++; if (bus.wb_count !== 2'd0) begin n_miss++; $display("FAIL reset_wb_count: got %0d expected 0", bus.wb_count); end
        n_vec++; if (bus.multi_hit_err !== 1'b0) begin n_miss++; $display("FAIL reset_multi_hit: got %b expected 0", bus.multi_hit_err); end
        $display("reset: strobes=%b way=%0d counters=%0d/%0d/%0d", strobes, bus.way_select,
                 bus.hit_count, bus.miss_count, bus.wb_count);
        tick();
    endtask

    task automatic test_read_hit();
        logic [1:0] ws [8];
        int resp_cyc = -1;
        int resp_n = 0;
        bus.lru_way = 2'd1;
        bus.hit = 1'b1;
        bus.which_way_hit = 4'b0100;
        bus.l2cmem_read = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            ws[c] = bus.way_select;
            if (bus.l2cmem_resp) begin
                resp_n++;
                if (resp_cyc < 0) resp_cyc = c;
                bus.l2cmem_read = 1'b0;
            end
            tick();
        end
        #1;
        n_vec++; if (resp_cyc !== 4) begin n_miss++; $display("FAIL hit_resp_cycle: got %0d expected 4", resp_cyc); end
        n_vec++; if (resp_n !== 1) begin n_miss++; $display("FAIL hit_resp_pulses: got %0d expected 1", resp_n); end
        n_vec++; if (ws[1] !== 2'd1) begin n_miss++; $display("FAIL hit_lookup_way: got %0d expected 1", ws[1]); end
        n_vec++; if (ws[3] !== 2'd2) begin n_miss++; $display("FAIL hit_check_way: got %0d expected 2", ws[3]); end
        n_vec++; if (ws[4] !== 2'd2) begin n_miss++; $display("FAIL hit_resp_way: got %0d expected 2", ws[4]); end
        n_vec++; if (bus.hit_count !== 2'd1) begin n_miss++; $display("FAIL hit_count_1: got %0d expected 1", bus.hit_count); end
        n_vec++; if (bus.miss_count !== 2'd0) begin n_miss++; $display("FAIL hit_miss_count: got %0d expected 0", bus.miss_count); end
        $display("read_hit: resp_cycle=%0d check_way=%0d hit_count=%0d", resp_cyc, ws[3], bus.hit_count);
        tick();
    endtask

    task automatic test_clean_read_miss();
        int rd_cycles = 0;
        bit seen_upd = 1'b0;
        bit got_resp = 1'b0;
        clear_counters();
        bus.hit = 1'b0;
        bus.which_way_hit = 4'b0000;
        bus.dirty_bit_out = 1'b0;
        bus.lru_way = 2'd3;
        bus.l2cmem_read = 1'b1;
        for (int c = 0; c < 40 && !got_resp; c++) begin
            bus.pmem_resp = bus.pmem_read && (rd_cycles == 4);
            #1;
            if (bus.pmem_read) rd_cycles++;
            if (bus.cache_write && !seen_upd) begin
                seen_upd = 1'b1;
                n_vec++; if (bus.way_select !== 2'd3) begin n_miss++; $display("FAIL fill_update_way: got %0d expected 3", bus.way_select); end
                n_vec++; if ({bus.valid_bit_in, bus.dirty_bit_in, bus.dirty_write_sel} !== 3'b100) begin
                    n_miss++; $display("FAIL fill_update_bits: got %b expected 100",
                                       {bus.valid_bit_in, bus.dirty_bit_in, bus.dirty_write_sel}); end
                bus.hit = 1'b1;
                bus.which_way_hit = 4'b1000;
            end
            if (bus.l2cmem_resp) begin
                got_resp = 1'b1;
                bus.l2cmem_read = 1'b0;
            end
            tick();
        end
        bus.pmem_resp = 1'b0;
        #1;
        n_vec++; if (got_resp !== 1'b1) begin n_miss++; $display("FAIL miss_resp: got %b expected 1", got_resp); end
        n_vec++; if (rd_cycles !== 5) begin n_miss++; $display("FAIL miss_pmem_read_cycles: got %0d expected 5", rd_cycles); end
        n_vec++; if (seen_upd !== 1'b1) begin n_miss++; $display("FAIL miss_update_seen: got %b expected 1", seen_upd); end
        n_vec++; if (bus.miss_count !== 2'd1) begin n_miss++; $display("FAIL miss_count_1: got %0d expected 1", bus.miss_count); end
        n_vec++; if (bus.hit_count !== 2'd0) begin n_miss++; $display("FAIL miss_hit_count: got %0d expected 0", bus.hit_count); end
        $display("clean_miss: pmem_read_cycles=%0d miss_count=%0d hit_count=%0d", rd_cycles,
                 bus.miss_count, bus.hit_count);
        tick();
    endtask

    task automatic test_dirty_write_miss();
        int wb_idx = 0;
        int fill_idx = 0;
        bit got_resp = 1'b0;
        bit saw_final = 1'b0;
        clear_counters();
        bus.hit = 1'b0;
        bus.which_way_hit = 4'b0000;
        bus.dirty_bit_out = 1'b1;
        bus.lru_way = 2'd2;
        bus.l2cmem_write = 1'b1;
        for (int c = 0; c < 60 && !got_resp; c++) begin
            if (bus.pmem_addr_sel) begin
                bus.ewb_blocking = (wb_idx < 3) || (wb_idx == 4);
                bus.pmem_resp    = (wb_idx == 5);
            end else if (bus.pmem_read) begin
                bus.ewb_blocking = 1'b0;
                bus.pmem_resp    = (fill_idx == 1);
            end else begin
                bus.ewb_blocking = 1'b0;
                bus.pmem_resp    = 1'b0;
            end
            #1;
            if (bus.pmem_addr_sel) begin
                n_vec++; if (bus.pmem_write !== 1'(wb_idx >= 3)) begin
                    n_miss++; $display("FAIL wb_pmem_write[%0d]: got %b expected %b", wb_idx,
                                       bus.pmem_write, 1'(wb_idx >= 3)); end
                wb_idx++;
            end
            if (bus.pmem_read) fill_idx++;
            if (bus.cache_write && !bus.dirty_bit_in) begin
                bus.hit = 1'b1;
                bus.which_way_hit = 4'b0100;
            end
            if (bus.cache_write && bus.dirty_bit_in) begin
                saw_final = 1'b1;
                n_vec++; if ({bus.valid_bit_in, bus.dirty_write_sel, bus.way_select} !== 4'b1110) begin
                    n_miss++; $display("FAIL wmiss_final_write: got %b expected 1110",
                                       {bus.valid_bit_in, bus.dirty_write_sel, bus.way_select}); end
            end
            if (bus.l2cmem_resp) begin
                got_resp = 1'b1;
                bus.l2cmem_write = 1'b0;
            end
            tick();
        end
        bus.pmem_resp = 1'b0;
        bus.ewb_blocking = 1'b0;
        bus.dirty_bit_out = 1'b0;
        #1;
        n_vec++; if (wb_idx !== 6) begin n_miss++; $display("FAIL wmiss_wb_cycles: got %0d expected 6", wb_idx); end
        n_vec++; if (saw_final !== 1'b1) begin n_miss++; $display("FAIL wmiss_final_seen: got %b expected 1", saw_final); end
        n_vec++; if (got_resp !== 1'b1) begin n_miss++; $display("FAIL wmiss_resp: got %b expected 1", got_resp); end
        n_vec++; if (bus.wb_count !== 2'd1) begin n_miss++; $display("FAIL wmiss_wb_count: got %0d expected 1", bus.wb_count); end
        n_vec++; if (bus.miss_count !== 2'd1) begin n_miss++; $display("FAIL wmiss_miss_count: got %0d expected 1", bus.miss_count); end
        n_vec++; if (bus.hit_count !== 2'd0) begin n_miss++; $display("FAIL wmiss_hit_count: got %0d expected 0", bus.hit_count); end
        $display("dirty_write_miss: wb_cycles=%0d wb_count=%0d miss_count=%0d", wb_idx,
                 bus.wb_count, bus.miss_count);
        tick();
    endtask

    task automatic test_saturation();
        int cyc;
        logic [1:0] w;
        clear_counters();
        bus.lru_way = 2'd0;
        for (int k = 0; k < 5; k++) do_req(1'b0, 4'b0010, 1'b0, cyc, w);
        #1;
        n_vec++; if (bus.hit_count !== 2'd3) begin n_miss++; $display("FAIL sat_hit_count: got %0d expected 3", bus.hit_count); end
        tick();
        do_req(1'b0, 4'b0010, 1'b1, cyc, w);
        #1;
        n_vec++; if (cyc !== 4) begin n_miss++; $display("FAIL clr_req_resp: got %0d expected 4", cyc); end
        n_vec++; if (bus.hit_count !== 2'd0) begin n_miss++; $display("FAIL clr_beats_inc: got %0d expected 0", bus.hit_count); end
        tick();
        do_req(1'b0, 4'b0010, 1'b0, cyc, w);
        #1;
        n_vec++; if (bus.hit_count !== 2'd1) begin n_miss++; $display("FAIL after_clr_hit: got %0d expected 1", bus.hit_count); end
        $display("saturation: last_resp_cycle=%0d hit_count=%0d", cyc, bus.hit_count);
        tick();
    endtask

    task automatic test_reset_in_fill();
        int fc = 0;
        int resp_n = 0;
        bit did = 1'b0;
        bus.hit = 1'b0;
        bus.which_way_hit = 4'b0000;
        bus.dirty_bit_out = 1'b0;
        bus.lru_way = 2'd1;
        bus.l2cmem_read = 1'b1;
        for (int c = 0; c < 20 && !did; c++) begin
            #1;
            if (bus.pmem_read) begin
                fc++;
                if (fc == 2) begin
                    rst = 1'b1;
                    did = 1'b1;
                end
            end
            tick();
        end
        rst = 1'b0;
        bus.l2cmem_read = 1'b0;
        #1;
        n_vec++; if (did !== 1'b1) begin n_miss++; $display("FAIL rstfill_reached_fill: got %b expected 1", did); end
        n_vec++; if (bus.pmem_read !== 1'b0) begin n_miss++; $display("FAIL rstfill_pmem_read: got %b expected 0", bus.pmem_read); end
        n_vec++; if ({bus.hit_count, bus.miss_count, bus.wb_count} !== 6'd0) begin
            n_miss++; $display("FAIL rstfill_counters: got %0d/%0d/%0d expected 0/0/0",
                               bus.hit_count, bus.miss_count, bus.wb_count); end
        for (int c = 0; c < 6; c++) begin
            if (bus.l2cmem_resp) resp_n++;
            tick();
            #1;
        end
        n_vec++; if (resp_n !== 0) begin n_miss++; $display("FAIL rstfill_no_resp: got %0d expected 0", resp_n); end
        $display("reset_in_fill: pmem_read=%b resp_pulses=%0d", bus.pmem_read, resp_n);
        tick();
    endtask

    task automatic test_multi_hit();
        int cyc;
        logic [1:0] w;
        bus.lru_way = 2'd3;
        do_req(1'b0, 4'b0110, 1'b0, cyc, w);
        #1;
        n_vec++; if (w !== 2'd1) begin n_miss++; $display("FAIL multi_way: got %0d expected 1", w); end
        n_vec++; if (bus.multi_hit_err !== 1'b1) begin n_miss++; $display("FAIL multi_err_set: got %b expected 1", bus.multi_hit_err); end
        tick();
        do_req(1'b1, 4'b0001, 1'b0, cyc, w);
        #1;
        n_vec++; if (cyc !== 4) begin n_miss++; $display("FAIL multi_next_resp: got %0d expected 4", cyc); end
        n_vec++; if (w !== 2'd0) begin n_miss++; $display("FAIL multi_next_way: got %0d expected 0", w); end
        n_vec++; if (bus.multi_hit_err !== 1'b1) begin n_miss++; $display("FAIL multi_err_sticky: got %b expected 1", bus.multi_hit_err); end
        $display("multi_hit: err=%b next_way=%0d", bus.multi_hit_err, w);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        bus.l2cmem_read   = 1'b0;
        bus.l2cmem_write  = 1'b0;
        bus.hit           = 1'b0;
        bus.which_way_hit = 4'b0000;
        bus.lru_way       = 2'd0;
        bus.dirty_bit_out = 1'b0;
        bus.ewb_blocking  = 1'b0;
        bus.pmem_resp     = 1'b0;
        bus.counter_clear = 1'b0;
        test_reset();
        test_read_hit();
        test_clean_read_miss();
        test_dirty_write_miss();
        test_saturation();
        test_reset_in_fill();
        test_multi_hit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/l2_cache_control_nway.md
Name: l2_cache_control_nway

Overview:
- Parametrised successor L2 cache controller FSM: N-way set-associative, write-back/write-allocate, configurable array access latency.
- Sits between the L1-side request port (l2cmem_*) and physical memory (pmem_*). Drives way select, array write enables and datapath mux selects.
- Adds binary LRU way input, full pmem handshakes, eviction-write-buffer stall, saturating hit/miss/writeback counters and a multi-hit error flag.

Parameters:
WAYS, 4, number of ways; power of 2, 2..8
WAY_W, $clog2(WAYS), way index width
ACCESS_DELAY, 2, cycles from request accept to valid tag/data outputs; 0..7
COUNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
l2cmem_read  in  1  read request; held until l2cmem_resp
l2cmem_write  in  1  write request; held until l2cmem_resp
hit  in  1  tag match in the indexed set
which_way_hit  in  WAYS  one-hot matching way (bit i = way i)
lru_way  in  WAY_W  victim way index from the LRU array
dirty_bit_out  in  1  dirty bit of the victim way
ewb_blocking  in  1  eviction write buffer full; stall
pmem_resp  in  1  pmem transfer complete
counter_clear  in  1  synchronous clear of all counters
l2cmem_resp  out  1  one-cycle request completion
cache_write  out  1  data/tag/valid/dirty array write enable
valid_bit_in  out  1  valid bit write value
dirty_bit_in  out  1  dirty bit write value
dirty_write_sel  out  1  1 = write data from l2cmem_wdata; 0 = from pmem_rdata
way_select  out  WAY_W  way addressed by the array write and read muxes
pmem_addr_sel  out  1  1 = victim tag address; 0 = request address
pmem_read  out  1  pmem read strobe
pmem_write  out  1  pmem write strobe
lru_update  out  1  one-cycle pulse marking way_select as MRU
hit_count  out  COUNT_W  saturating hit count
miss_count  out  COUNT_W  saturating miss count
wb_count  out  COUNT_W  saturating dirty-writeback count
multi_hit_err  out  1  sticky: which_way_hit not one-hot while hit=1

Behaviour:
- Reset: state IDLE, delay counter 0, missed flag 0, all counters 0, multi_hit_err 0. Every output is combinational from state and is 0 in IDLE.
- Outputs are Moore-style except way_select and the CHECK-state write strobes. way_select defaults to 0.
- IDLE: when l2cmem_read|l2cmem_write, go to LOOKUP. If ACCESS_DELAY=0, go straight to CHECK.
- LOOKUP: hold for ACCESS_DELAY cycles using a down-counter, then go to CHECK. Drive way_select=lru_way.
- CHECK:
  - If ewb_blocking, stay in CHECK with no strobes.
  - Else if hit: way_select = index of which_way_hit. If the request is a write, assert cache_write=valid_bit_in=dirty_bit_in=dirty_write_sel=1 for this one cycle. Go to RESP.
  - Else if dirty_bit_out: go to WB.
  - Else: go to FILL.
- RESP: l2cmem_resp=1 and lru_update=1, way_select held. Next state IDLE. The request is complete, so the L1 side may drop or change the request in the next cycle.
- WB:
  - way_select=lru_way, pmem_addr_sel=1.
  - pmem_write=1 only while !ewb_blocking. Once asserted, it stays high until pmem_resp is sampled, even if ewb_blocking rises.
  - On pmem_resp go to FILL; pmem_write is low the next cycle.
- FILL: pmem_addr_sel=0, pmem_read=1 held until pmem_resp; then go to UPDATE.
- UPDATE: way_select=lru_way, cache_write=1, valid_bit_in=1, dirty_bit_in=0, dirty_write_sel=0. Go to LOOKUP so the arrays re-read; with ACCESS_DELAY=0 go to CHECK.
- missed flag:
  - Set on CHECK->WB and CHECK->FILL.
  - Cleared on RESP.
  - A post-fill hit is a miss completion, not a hit.
- Counters:
  - hit_count +1 on CHECK->RESP with missed=0.
  - miss_count +1 on CHECK->WB/FILL.
  - wb_count +1 on leaving WB.
  - All counters saturate at 2^COUNT_W-1.
  - counter_clear wins over a same-cycle increment.
- multi_hit_err: set in CHECK when hit=1 and which_way_hit is zero or multi-hot. Cleared only by rst. In that case way_select is the lowest set bit (0 if none).
- A write request that misses completes as a hit write after the refill. Dirty is set then.
- Reset mid-operation (including WB/FILL): the next cycle is IDLE with all strobes low. No resp is issued for the aborted request.
- Read and write both high: treat as a write.

Test Plan:
- ACCESS_DELAY=2, read with hit=1, which_way_hit=4'b0100 -> way_select=2 in CHECK; l2cmem_resp high exactly at cycle 4 after request (IDLE, LOOKUPx2, CHECK, RESP); hit_count=1.
- Clean read miss (dirty_bit_out=0, lru_way=3), pmem_resp after 5 cycles, then hit -> pmem_read high 5 cycles; cache_write in UPDATE with way_select=3, dirty_bit_in=0; miss_count=1, hit_count=0.
- Dirty write miss with ewb_blocking high 3 cycles in WB -> pmem_write stays low 3 cycles then high until pmem_resp; wb_count=1; final CHECK write has dirty_bit_in=1, dirty_write_sel=1.
- COUNT_W=2, 5 read hits -> hit_count stays 3; counter_clear on the same cycle as a hit -> hit_count=0.
- rst asserted during FILL -> next cycle pmem_read=0, state IDLE, counters 0, no l2cmem_resp.
- hit=1 with which_way_hit=4'b0110 -> multi_hit_err=1 and stays 1 through later requests; way_select=1.
